shift_result_buffer: RTL and testbench
======================================

SHIFT_RESULT_BUFFER -- requirements
Module: shift_result_buffer

Interface
REQ-001 Parameter WIDTH, default 16, data width of the shifter result.
REQ-002 Parameter DEPTH, default 4, number of buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  upstream shifter result valid.
REQ-006 in_ready  output  1  buffer can accept a result this cycle.
REQ-007 in  input  WIDTH  shifter result (arithmetic shifter "out").
REQ-008 ov  input  1  shifter overflow flag accompanying in.
REQ-009 out_valid  output  1  head entry valid.
REQ-010 out_ready  input  1  downstream consumes head this cycle.
REQ-011 out  output  WIDTH  head entry data.
REQ-012 out_ov  output  1  overflow flag stored with head entry.
REQ-013 out_zero  output  1  head data equals zero.
REQ-014 out_neg  output  1  head data bit WIDTH-1.
REQ-015 sticky_ov  output  1  set by any accepted entry with ov=1, held until cleared.
REQ-016 clr_sticky  input  1  clears sticky_ov.
REQ-017 count  output  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 Push occurs when in_valid and in_ready are both 1; pop occurs when out_valid and out_ready are both 1.
REQ-019 in_ready shall equal (count != DEPTH), with no combinational dependence on out_ready.
REQ-020 out_valid shall equal (count != 0).
REQ-021 Each entry stores {ov, zero, data}; zero flag computed at push time from in.
REQ-022 Latency: a pushed entry becomes visible on out/out_valid in the cycle after the push; no combinational bypass from in to out.
REQ-023 When out_valid=0, out, out_ov, out_zero, out_neg shall all be 0.
REQ-024 Write and read pointers are clog2(DEPTH) bits and wrap modulo DEPTH without gaps.
REQ-025 Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
REQ-026 Simultaneous push and pop with count=0: only the push takes effect (out_valid was 0); count becomes 1.
REQ-027 count=DEPTH: in_ready=0, in_valid ignored even if out_ready=1 that cycle; pop proceeds normally.
REQ-028 Entries are delivered strictly in push order; data and flags never modified while stored.
REQ-029 sticky_ov next = (sticky_ov and not clr_sticky) or (push and ov); set wins over simultaneous clear.
REQ-030 out held stable while out_valid=1 and out_ready=0.

Reset
REQ-031 On reset: count=0, pointers=0, sticky_ov=0, out_valid=0, in_ready=1, out/out_ov/out_zero/out_neg=0.
REQ-032 Reset asserted mid-operation discards all stored entries; push/pop in that cycle has no effect.
REQ-033 Storage array contents need no reset; outputs are masked by REQ-023.

Structure
REQ-034 Package shift_buf_pkg holds WIDTH and DEPTH defaults, pointer width, count width, and the entry field layout.
REQ-035 Storage shall be one sub-module shift_buf_mem (DEPTH x (WIDTH+2) register array, one write port, one asynchronous read port); control lives in shift_result_buffer.

Verification
REQ-036 After reset, push 0x8001 ov=1 -> next cycle out=0x8001, out_ov=1, out_neg=1, out_zero=0, count=1, sticky_ov=1.
REQ-037 Push 0x0000,0x0001,0x0002,0x0003 with out_ready=0 -> count=4, in_ready=0; 5th push 0x0004 ignored; pops yield 0x0000(out_zero=1),0x0001,0x0002,0x0003 in order.
REQ-038 Hold count=2, drive push and pop every cycle for 10 cycles -> count stays 2, pointers wrap, output sequence matches input order exactly.
REQ-039 count=0, in_valid=1, out_ready=1 same cycle -> out_valid=0 that cycle, 1 next cycle, count=1.
REQ-040 sticky_ov=1, clr_sticky=1 with push ov=1 same cycle -> sticky_ov stays 1; next cycle clr_sticky=1 alone -> 0.
REQ-041 count=3, assert reset for one cycle with push active -> count=0, out_valid=0, out=0, sticky_ov=0 next cycle.

Source files
------------

// File: rtl/shift_buf_pkg.sv
// Shared defaults and entry layout for the shifter result buffer.
// An entry is packed as {ov, zero, data}, with data in the low WIDTH bits.
package shift_buf_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 4;
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
  localparam int CNT_W_DEF = PTR_W_DEF + 1;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int entry_w(input int width);
    return width + 2;
  endfunction

  function automatic int ov_bit(input int width);
    return width + 1;
  endfunction

  function automatic int zero_bit(input int width);
    return width;
  endfunction

endpackage

// File: rtl/shift_buf_mem.sv
// Entry storage for the result buffer: one synchronous write port and one
// asynchronous read port. Contents are not reset; the control logic masks them.
module shift_buf_mem #(
  parameter int EW    = 18,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);

  logic [EW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/shift_result_buffer.sv
// In-order FIFO for arithmetic shifter results, tagging each entry with its
// overflow and zero flags and keeping a sticky overflow indicator.
module shift_result_buffer
  import shift_buf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in,
  input  logic                      ov,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out,
  output logic                      out_ov,
  output logic                      out_zero,
  output logic                      out_neg,
  output logic                      sticky_ov,
  input  logic                      clr_sticky,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int EW = entry_w(WIDTH);
  localparam int OVB = ov_bit(WIDTH);
  localparam int ZB = zero_bit(WIDTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;

  // Readiness depends only on stored state, never on out_ready.
  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign wdata = {ov, (in == '0), in};

  shift_buf_mem #(
    .EW    (EW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~reset),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      sticky_ov <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // A new overflow wins over a clear in the same cycle.
      sticky_ov <= (sticky_ov & ~clr_sticky) | (push & ov);
    end
  end

  // Stale storage never leaks out when the buffer is empty.
  assign out      = out_valid ? rdata[WIDTH-1:0] : '0;
  assign out_ov   = out_valid & rdata[OVB];
  assign out_zero = out_valid & rdata[ZB];
  assign out_neg  = out_valid & rdata[WIDTH-1];

endmodule

// File: tb/tb_shift_result_buffer.sv
// Directed bench for shift_result_buffer with a queue scoreboard of expected entries.
module tb_shift_result_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        ov;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in = '0;
  logic        ov = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out;
  logic        out_ov;
  logic        out_zero;
  logic        out_neg;
  logic        sticky_ov;
  logic        clr_sticky = 1'b0;
  logic [2:0]  count;

  exp_t q[$];
  logic m_sticky = 1'b0;
  int   errors = 0;
  int   checks = 0;

  shift_result_buffer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in         (in),
    .ov         (ov),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out        (out),
    .out_ov     (out_ov),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .sticky_ov  (sticky_ov),
    .clr_sticky (clr_sticky),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare outputs against the model, then advance the model.
  task automatic step(input logic iv, input logic [15:0] d, input logic dov,
                      input logic ordy, input logic clr);
    exp_t e;
    logic full;
    logic did_push;
    @(negedge clk);
    reset = 1'b0; in_valid = iv; in = d; ov = dov; out_ready = ordy; clr_sticky = clr;
    #1;
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("sticky_ov", 32'(sticky_ov), 32'(m_sticky));
    if (q.size() == 0) begin
      check("out_empty", {13'd0, out_ov, out_zero, out_neg, out}, 32'd0);
    end else begin
      e = q[0];
      check("out_data", 32'(out), 32'(e.data));
      check("out_ov", 32'(out_ov), 32'(e.ov));
      check("out_zero", 32'(out_zero), 32'(e.data == 16'd0));
      check("out_neg", 32'(out_neg), 32'(e.data[15]));
    end
    full = (q.size() == DEPTH);
    did_push = iv && !full;
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (did_push) q.push_back('{ov: dov, data: d});
    m_sticky = (m_sticky & ~clr) | (did_push & dov);
  endtask

  task automatic do_reset(input logic iv);
    @(negedge clk);
    reset = 1'b1; in_valid = iv; in = 16'h7777; ov = 1'b1; out_ready = 1'b1; clr_sticky = 1'b0;
    @(posedge clk);
    q.delete();
    m_sticky = 1'b0;
  endtask

  initial begin
    do_reset(1'b0);
    step(0, 16'h0, 0, 0, 0);

    // single overflowed negative result
    step(1, 16'h8001, 1, 0, 0);
    step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 0);

    // fill to full, extra push ignored, drain in order
    for (int i = 0; i < 4; i++) step(1, 16'(i), 0, 0, 0);
    step(1, 16'h0004, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 0, 0, 0);

    // steady push+pop at occupancy two, pointers wrap
    step(1, 16'hA000, 0, 0, 0);
    step(1, 16'h0A01, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 16'h0010 + 16'(i * 16'h1111), (i % 3) == 0, 1, 0);
    step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 0, 0, 1);

    // push and pop offered on an empty buffer
    step(1, 16'h0055, 0, 1, 0);
    step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 0, 0, 0);

    // sticky set wins over clear
    step(1, 16'hFFFF, 1, 1, 0);
    step(1, 16'h1234, 1, 1, 1);
    step(0, 16'h0, 0, 1, 1);
    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);

    // reset mid-operation with a push active
    step(1, 16'h0101, 1, 0, 0);
    step(1, 16'h0202, 0, 0, 0);
    step(1, 16'h0303, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    do_reset(1'b1);
    step(0, 16'h0, 0, 0, 0);
    step(1, 16'h4242, 0, 0, 0);
    step(0, 16'h0, 0, 1, 0);
    step(0, 16'h0, 0, 0, 0);

    if (q.size() != 0) check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
